// File: rtl/alu_pkg.sv
// Shared types for the ALU execute stage: the ALUControl encoding and the stage FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_SLTU = 4'b1000,
    ALU_XOR  = 4'b1001,
    ALU_SLL  = 4'b1010,
    ALU_SRL  = 4'b1011,
    ALU_SRA  = 4'b1100
  } alu_ctrl_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } exec_state_e;

  function automatic logic is_shift(input alu_ctrl_e c);
    return (c == ALU_SLL) || (c == ALU_SRL) || (c == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Single-cycle combinational ALU. Shift codes return op A unchanged: the core is
// only consulted for shifts when the shift amount is zero.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  alu_ctrl_e         i_ctrl,
  input  logic [XLEN-1:0]   i_a,
  input  logic [XLEN-1:0]   i_b,
  output logic [XLEN-1:0]   o_result
);

  logic w_lt_signed;
  logic w_lt_unsigned;

  assign w_lt_signed   = $signed(i_a) < $signed(i_b);
  assign w_lt_unsigned = i_a < i_b;

  always_comb begin
    o_result = '0;
    unique case (i_ctrl)
      ALU_AND:  o_result = i_a & i_b;
      ALU_OR:   o_result = i_a | i_b;
      ALU_XOR:  o_result = i_a ^ i_b;
      ALU_SUB:  o_result = i_a - i_b;
      ALU_SLT:  o_result[0] = w_lt_signed;
      ALU_SLTU: o_result[0] = w_lt_unsigned;
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:  o_result = i_a;
      default:  o_result = i_a + i_b;
    endcase
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: one-cycle ALU ops plus iterative one-bit-per-cycle shifts,
// with valid/ready handshakes on both sides and a registered result.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  alu_ctrl_e       alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy
);

  exec_state_e          r_state, w_state_nxt;
  logic [XLEN-1:0]      r_work, w_work_nxt;
  logic [SHAMT_W-1:0]   r_cnt, w_cnt_nxt;
  alu_ctrl_e            r_kind, w_kind_nxt;
  logic [XLEN-1:0]      r_result, w_result_nxt;
  logic                 r_zero, w_zero_nxt;
  logic                 r_out_valid, w_out_valid_nxt;

  logic [XLEN-1:0]      w_core_result;
  logic [XLEN-1:0]      w_work_step;
  logic [SHAMT_W-1:0]   w_shamt;
  logic                 w_accept;

  alu_core #(.XLEN(XLEN)) u_core (
    .i_ctrl   (alu_ctrl),
    .i_a      (op_a),
    .i_b      (op_b),
    .o_result (w_core_result)
  );

  assign w_shamt  = op_b[SHAMT_W-1:0];
  assign in_ready = (r_state == IDLE) && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_work_step = r_work;
    unique case (r_kind)
      ALU_SLL: w_work_step = r_work << 1;
      ALU_SRL: w_work_step = r_work >> 1;
      default: w_work_step = {r_work[XLEN-1], r_work[XLEN-1:1]};
    endcase
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_work_nxt      = r_work;
    w_cnt_nxt       = r_cnt;
    w_kind_nxt      = r_kind;
    w_result_nxt    = r_result;
    w_zero_nxt      = r_zero;
    // A consumed result drops unless a new one is written below on the same edge.
    w_out_valid_nxt = r_out_valid && !out_ready;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (is_shift(alu_ctrl) && (w_shamt != '0)) begin
            w_state_nxt = SHIFT;
            w_work_nxt  = op_a;
            w_cnt_nxt   = w_shamt;
            w_kind_nxt  = alu_ctrl;
          end else begin
            w_result_nxt    = w_core_result;
            w_zero_nxt      = (w_core_result == '0);
            w_out_valid_nxt = 1'b1;
          end
        end
      end
      SHIFT: begin
        w_work_nxt = w_work_step;
        w_cnt_nxt  = r_cnt - 1'b1;
        if (r_cnt == SHAMT_W'(1)) begin
          w_state_nxt     = IDLE;
          w_result_nxt    = w_work_step;
          w_zero_nxt      = (w_work_step == '0);
          w_out_valid_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_work      <= '0;
      r_cnt       <= '0;
      r_kind      <= ALU_SLL;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_work      <= w_work_nxt;
      r_cnt       <= w_cnt_nxt;
      r_kind      <= w_kind_nxt;
      r_result    <= w_result_nxt;
      r_zero      <= w_zero_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign busy      = (r_state == SHIFT);

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed, table-driven bench for alu_exec_stage with hand-written handshake sequences.
module tb_alu_exec_stage;
  import alu_pkg::*;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  alu_ctrl_e       alu_ctrl;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            busy;

  int n_cmp  = 0;
  int n_fail = 0;

  alu_exec_stage #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    alu_ctrl_e   ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    int unsigned wait_n;   // edges after the accept edge before out_valid shows
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input string name, input alu_ctrl_e c, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] res, input logic z,
                              input int unsigned w);
    vec_t v;
    v.name = name; v.ctrl = c; v.a = a; v.b = b; v.res = res; v.z = z; v.wait_n = w;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int unsigned n;
    in_valid  = 1'b1;
    alu_ctrl  = v.ctrl;
    op_a      = v.a;
    op_b      = v.b;
    out_ready = 1'b0;
    check({v.name, " in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    op_a     = 32'hDEAD_BEEF;
    op_b     = 32'h0000_0003;
    n = 0;
    while (!out_valid && n < 64) begin
      check({v.name, " busy"}, 32'(busy), 32'd1);
      check({v.name, " in_ready_busy"}, 32'(in_ready), 32'd0);
      tick();
      n++;
    end
    check({v.name, " wait"}, n, v.wait_n);
    check({v.name, " result"}, result, v.res);
    check({v.name, " zero"}, 32'(zero), 32'(v.z));
    check({v.name, " busy_done"}, 32'(busy), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({v.name, " out_valid_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    bit seen;

    vecs[0]  = mk("add_wrap",  ALU_ADD,  32'h7FFF_FFFF, 32'h1,  32'h8000_0000, 1'b0, 0);
    vecs[1]  = mk("sub_zero",  ALU_SUB,  32'h5,         32'h5,  32'h0,         1'b1, 0);
    vecs[2]  = mk("unknown",   alu_ctrl_e'(4'hF), 32'h3, 32'h4, 32'h7,         1'b0, 0);
    vecs[3]  = mk("slt",       ALU_SLT,  32'hFFFF_FFFF, 32'h1,  32'h1,         1'b0, 0);
    vecs[4]  = mk("sltu",      ALU_SLTU, 32'hFFFF_FFFF, 32'h1,  32'h0,         1'b1, 0);
    vecs[5]  = mk("and",       ALU_AND,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 0);
    vecs[6]  = mk("or",        ALU_OR,   32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF, 1'b0, 0);
    vecs[7]  = mk("xor",       ALU_XOR,  32'h0000_FFFF, 32'h0000_FF00, 32'h0000_00FF, 1'b0, 0);
    vecs[8]  = mk("sub_neg",   ALU_SUB,  32'h0,         32'h1,  32'hFFFF_FFFF, 1'b0, 0);
    vecs[9]  = mk("sra31",     ALU_SRA,  32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, 31);
    vecs[10] = mk("sll0",      ALU_SLL,  32'h1,         32'd0,  32'h1,         1'b0, 0);
    vecs[11] = mk("srl4",      ALU_SRL,  32'h0000_00F0, 32'd4,  32'h0000_000F, 1'b0, 4);
    vecs[12] = mk("sll31",     ALU_SLL,  32'h1,         32'd31, 32'h8000_0000, 1'b0, 31);
    vecs[13] = mk("sra_pos",   ALU_SRA,  32'h7FFF_FFFF, 32'd4,  32'h07FF_FFFF, 1'b0, 4);
    vecs[14] = mk("sll_mask",  ALU_SLL,  32'h3,         32'h21, 32'h6,         1'b0, 1);
    vecs[15] = mk("srl_zero",  ALU_SRL,  32'h0000_0080, 32'd8,  32'h0,         1'b1, 8);

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    alu_ctrl  = ALU_ADD;
    op_a      = '0;
    op_b      = '0;
    out_ready = 1'b0;
    #1;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst result", result, 32'd0);
    check("rst zero", 32'(zero), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) run_vec(vecs[i]);

    // Reset in the middle of an SRL by 20.
    in_valid = 1'b1; alu_ctrl = ALU_SRL; op_a = 32'hFFFF_F000; op_b = 32'd20;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    check("midshift busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst out_valid", 32'(out_valid), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst in_ready", 32'(in_ready), 32'd1);
    check("midrst result", result, 32'd0);
    #2;
    rst_n = 1'b1;
    seen = 1'b0;
    out_ready = 1'b0;
    repeat (30) begin
      tick();
      if (out_valid || busy) seen = 1'b1;
    end
    check("midrst no stale result", 32'(seen), 32'd0);

    // Backpressure: ADD 2+3 held for 5 cycles, new op accepted on release.
    in_valid = 1'b1; alu_ctrl = ALU_ADD; op_a = 32'd2; op_b = 32'd3; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp out_valid", 32'(out_valid), 32'd1);
      check("bp result", result, 32'd5);
      check("bp in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    in_valid = 1'b1; op_a = 32'd10; op_b = 32'd20; out_ready = 1'b1;
    #1;
    check("bp release in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check("bp new out_valid", 32'(out_valid), 32'd1);
    check("bp new result", result, 32'd30);
    out_ready = 1'b1;
    tick();
    check("bp drained", 32'(out_valid), 32'd0);

    // Throughput: 8 back-to-back ADDs with downstream always ready.
    out_ready = 1'b1;
    alu_ctrl  = ALU_ADD;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; op_a = 32'(i); op_b = 32'd100;
      check("tp in_ready", 32'(in_ready), 32'd1);
      tick();
      check("tp out_valid", 32'(out_valid), 32'd1);
      check("tp result", result, 32'(100 + i));
    end
    in_valid = 1'b0;
    tick();
    check("tp drain", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
